ysyx_23060201_store_buf: RTL and testbench

YSYX_23060201_STORE_BUF -- requirements
Module: ysyx_23060201_store_buf

---
 rtl/ysyx_23060201_store_buf.sv | 126 ++++++++++++
 tb/tb_ysyx_23060201_store_buf.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_store_buf.sv
// Store buffer: aligns byte/half/word stores into word-lane writes and queues
// them in a small circular FIFO in front of the memory write port.
module ysyx_23060201_store_buf #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [1:0]                    in_size,
  input  logic                          mem_ready,
  output logic                          mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [7:0]                    mem_wmask,
  output logic                          misalign_err,
  output logic [MEM_ADDR_WIDTH-1:0]     err_addr,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  logic [MEM_ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0]     r_data [DEPTH];
  logic [3:0]                r_mask [DEPTH];

  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_count;
  logic                      r_err;
  logic [MEM_ADDR_WIDTH-1:0] r_err_addr;

  size_e                     w_size;
  logic [1:0]                w_off;
  logic                      w_legal;
  logic [3:0]                w_mask;
  logic [DATA_WIDTH-1:0]     w_wdata;
  logic [MEM_ADDR_WIDTH-1:0] w_waddr;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;

  assign w_size  = size_e'(in_size);
  assign w_off   = in_addr[1:0];
  assign w_waddr = {in_addr[MEM_ADDR_WIDTH-1:2], 2'b00};

  // Lane placement is computed at enqueue so the drain side is a plain read.
  always_comb begin
    w_legal = 1'b0;
    w_mask  = '0;
    w_wdata = '0;
    unique case (w_size)
      SZ_BYTE: begin
        w_legal = 1'b1;
        w_mask  = 4'b0001 << w_off;
        w_wdata = DATA_WIDTH'(in_data[7:0]) << {w_off, 3'b000};
      end
      SZ_HALF: begin
        w_legal = ~in_addr[0];
        w_mask  = 4'b0011 << w_off;
        w_wdata = DATA_WIDTH'(in_data[15:0]) << {w_off, 3'b000};
      end
      SZ_WORD: begin
        w_legal = (w_off == 2'b00);
        w_mask  = 4'b1111;
        w_wdata = in_data;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept = in_valid && in_ready && !rst;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = mem_wen;

  // Strobe is masked while reset is held so nothing leaves a buffer being flushed.
  assign mem_wen   = !rst && (r_count != '0) && mem_ready;
  assign mem_waddr = mem_wen ? r_addr[r_head] : '0;
  assign mem_wdata = mem_wen ? r_data[r_head] : '0;
  assign mem_wmask = mem_wen ? {4'b0000, r_mask[r_head]} : '0;

  assign misalign_err = r_err;
  assign err_addr     = r_err_addr;
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= w_waddr;
        r_data[r_tail] <= w_wdata;
        r_mask[r_tail] <= w_mask;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_err   <= w_accept && !w_legal;
      if (w_accept && !w_legal) begin
        r_err_addr <= in_addr;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_store_buf.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// directed stores with hand-computed write expectations.
module tb_ysyx_23060201_store_buf;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AW-1:0]   in_addr = '0;
  logic [DW-1:0]   in_data = '0;
  logic [1:0]      in_size = '0;
  logic            mem_ready = 1'b1;
  logic            mem_wen;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic [7:0]      mem_wmask;
  logic            misalign_err;
  logic [AW-1:0]   err_addr;
  logic [$clog2(DEPTH):0] count;

  ysyx_23060201_store_buf #(
    .MEM_ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .misalign_err(misalign_err), .err_addr(err_addr), .count(count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of pending writes, built byte by byte.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  m;
  } wr_t;

  wr_t         mq[$];
  bit          m_err = 0;
  logic [31:0] m_err_addr = '0;
  bit          started = 0;
  bit          in_wrap = 0;
  int          wr_seen = 0;

  function automatic void lanes(input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d, output bit legal, output wr_t e);
    int nbytes;
    int off;
    nbytes = 1 << sz;
    off    = int'(a % 4);
    legal  = (sz != 2'd3) && (a % nbytes == 0);
    e.a = a - off;
    e.d = '0;
    e.m = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + nbytes) begin
        e.m[i] = 1'b1;
        e.d[8*i +: 8] = d[8*(i-off) +: 8];
      end
    end
  endfunction

  always @(posedge clk) begin
    bit  pop;
    bit  acc;
    bit  legal;
    wr_t e;
    if (rst) begin
      mq.delete();
      m_err      = 0;
      m_err_addr = '0;
      started    = 1;
    end else begin
      pop = (mq.size() != 0) && mem_ready;
      acc = in_valid && (mq.size() < DEPTH);
      if (pop) void'(mq.pop_front());
      m_err = 0;
      if (acc) begin
        lanes(in_size, in_addr, in_data, legal, e);
        if (legal) mq.push_back(e);
        else begin
          m_err      = 1;
          m_err_addr = in_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_wen;
    if (started) begin
      exp_wen = !rst && (mq.size() != 0) && mem_ready;
      check("mem_wen",   mem_wen,   exp_wen);
      check("mem_waddr", mem_waddr, exp_wen ? mq[0].a : 32'h0);
      check("mem_wdata", mem_wdata, exp_wen ? mq[0].d : 32'h0);
      check("mem_wmask", mem_wmask, exp_wen ? mq[0].m : 8'h0);
      check("count",     count,     mq.size());
      check("misalign",  misalign_err, m_err);
      check("err_addr",  err_addr,  m_err_addr);
      if (!rst) check("in_ready", in_ready, mq.size() < DEPTH);
      if (in_wrap) check("wrap_count_le1", count <= 1, 1);
      if (mem_wen) wr_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_size  = s;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [1:0] wsz  [10] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
  logic [1:0] woff [10] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0};

  initial begin
    int base;

    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wen",      mem_wen, 0);
    check("rst_waddr",    mem_waddr, 0);
    check("rst_wmask",    mem_wmask, 0);
    check("rst_count",    count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err",      misalign_err, 0);
    tick();

    // Byte store into the top lane
    req(2'd0, 32'h8000_0003, 32'h0000_00AB);
    @(negedge clk);
    check("byte_wen",   mem_wen, 1);
    check("byte_waddr", mem_waddr, 32'h8000_0000);
    check("byte_wdata", mem_wdata, 32'hAB00_0000);
    check("byte_wmask", mem_wmask, 8'h08);
    tick();

    // Half store into the upper half
    req(2'd1, 32'h8000_0006, 32'h0000_1234);
    @(negedge clk);
    check("half_wen",   mem_wen, 1);
    check("half_waddr", mem_waddr, 32'h8000_0004);
    check("half_wdata", mem_wdata, 32'h1234_0000);
    check("half_wmask", mem_wmask, 8'h0C);
    tick();

    // Misaligned word is dropped and reported for one cycle
    req(2'd2, 32'h8000_0002, 32'hDEAD_BEEF);
    @(negedge clk);
    check("mis_err",   misalign_err, 1);
    check("mis_addr",  err_addr, 32'h8000_0002);
    check("mis_wen",   mem_wen, 0);
    check("mis_count", count, 0);
    tick();
    @(negedge clk);
    check("mis_err_pulse", misalign_err, 0);
    check("mis_addr_hold", err_addr, 32'h8000_0002);
    tick();

    req(2'd1, 32'h8000_0005, 32'h0000_5555);
    req(2'd3, 32'h8000_0010, 32'h0000_0001);
    @(negedge clk);
    check("size3_err",  misalign_err, 1);
    check("size3_addr", err_addr, 32'h8000_0010);
    tick();

    // Fill with the write port stalled; fifth store must wait
    mem_ready = 1'b0;
    in_valid  = 1'b1;
    in_size   = 2'd2;
    for (int i = 0; i < 5; i++) begin
      in_addr = 32'h8000_1000 + 32'(4 * i);
      in_data = 32'h0000_1000 + 32'(i);
      tick();
      if (i == 3) begin
        check("fill_count", count, 4);
        check("fill_ready", in_ready, 0);
      end
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_wen",   mem_wen, 1);
      check("drain_waddr", mem_waddr, 32'h8000_1000 + 32'(4 * i));
      check("drain_wdata", mem_wdata, 32'h0000_1000 + 32'(i));
      check("drain_wmask", mem_wmask, 8'h0F);
      tick();
    end
    @(negedge clk);
    check("drain_count", count, 0);
    check("drain_ready", in_ready, 1);
    check("drain_wen_off", mem_wen, 0);
    tick();

    // Continuous streaming wraps the pointers
    base    = wr_seen;
    in_wrap = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_size  = wsz[i];
      in_addr  = 32'h8000_2000 + 32'(8 * i) + 32'(woff[i]);
      in_data  = 32'hA5C3_0000 + 32'(i * 32'h0101);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    in_wrap = 0;
    check("wrap_writes", wr_seen - base, 10);

    // Intermittent backpressure while streaming
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      mem_ready = (i % 3) != 0;
      in_size   = 2'd2;
      in_addr   = 32'h8000_3000 + 32'(4 * i);
      in_data   = 32'h3000_0000 + 32'(i);
      tick();
    end
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    check("bp_empty", count, 0);
    tick();

    // Reset in the middle of queued work discards everything
    mem_ready = 1'b0;
    req(2'd2, 32'h8000_4000, 32'h1111_1111);
    req(2'd2, 32'h8000_4004, 32'h2222_2222);
    req(2'd2, 32'h8000_4008, 32'h3333_3333);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_size  = 2'd2;
    in_addr  = 32'h8000_400C;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    base      = wr_seen;
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_wen",   mem_wen, 0);
    tick();
    tick();
    tick();
    check("mid_rst_nowrite", wr_seen - base, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
